// File: rtl/basys_io_periph.sv
// Memory-mapped board I/O block for the Basys3 CPU system. It groups the
// LEDs, switches, push-buttons and the multiplexed 7-segment display behind
// one register slave port.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   addr_i         byte address; [4:2] select the register, [1:0] are ignored
//   we_i, re_i     single-cycle write / read strobes
//   wdata_i        write data
//   rdata_o        registered read data, valid the cycle after re_i
//   led_o          LED drive (active-high)
//   sw_i, btn_i    raw asynchronous switches / buttons
//   seg_o, dp_o    segments a..g (bit0 = a) and decimal point, active-low
//   an_o           digit anodes, active-low, one-hot-low
//
// Register map: 0x00 LED, 0x04 SW, 0x08 BTN, 0x0C EVT (W1C), 0x10 HEX,
// 0x14 CTRL {enable[16], dp_mask[15:8], blank_mask[7:0]}, 0x18/0x1C read 0.
module basys_io_periph #(
    parameter int unsigned N_LED      = 16,
    parameter int unsigned N_SW       = 16,
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned DEB_CYCLES = 10000,
    parameter int unsigned REF_CYCLES = 2500
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       addr_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic [N_LED-1:0] led_o,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [6:0]       seg_o,
    output logic             dp_o,
    output logic [N_DIG-1:0] an_o
);

    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
    localparam int unsigned REF_W = $clog2(REF_CYCLES);

    localparam logic [2:0] SEL_LED  = 3'd0;
    localparam logic [2:0] SEL_SW   = 3'd1;
    localparam logic [2:0] SEL_BTN  = 3'd2;
    localparam logic [2:0] SEL_EVT  = 3'd3;
    localparam logic [2:0] SEL_HEX  = 3'd4;
    localparam logic [2:0] SEL_CTRL = 3'd5;

    logic [2:0]         sel;
    logic [N_SW-1:0]    sw_s1, sw_s2;
    logic [N_BTN-1:0]   btn_s1, btn_s2;
    logic [N_BTN-1:0]   btn_deb, deb_next, rise, evt, evt_clr;
    logic [DEB_W-1:0]   deb_cnt  [N_BTN];
    logic [DEB_W-1:0]   cnt_next [N_BTN];
    logic [4*N_DIG-1:0] hex_r;
    logic [N_DIG-1:0]   blank_r, dpm_r;
    logic               en_r;
    logic [REF_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   dig_idx;
    logic [3:0]         nibble;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign sel         = addr_i[4:2];
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    // Active-low 7-segment decode of one hex digit, bit0 = segment a.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= sw_i;
            sw_s2  <= sw_s1;
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: a button must differ from its accepted level for DEB_CYCLES
    // consecutive cycles before the new level is taken.
    always_comb begin
        deb_next = btn_deb;
        rise     = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_next[i] = '0;
            if (btn_s2[i] != btn_deb[i]) begin
                if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_next[i] = btn_s2[i];
                    rise[i]     = btn_s2[i];
                end else begin
                    cnt_next[i] = deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_deb <= '0;
            for (int i = 0; i < int'(N_BTN); i++) deb_cnt[i] <= '0;
        end else begin
            btn_deb <= deb_next;
            for (int i = 0; i < int'(N_BTN); i++) deb_cnt[i] <= cnt_next[i];
        end
    end

    // A press landing in the same cycle as its W1C clear keeps the flag set.
    assign evt_clr = (we_i && sel == SEL_EVT) ? wdata_i[N_BTN-1:0] : '0;

    // Writable registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_o   <= '0;
            evt     <= '0;
            hex_r   <= '0;
            blank_r <= '0;
            dpm_r   <= '0;
            en_r    <= 1'b0;
        end else begin
            evt <= (evt & ~evt_clr) | rise;
            if (we_i) begin
                case (sel)
                    SEL_LED:  led_o <= wdata_i[N_LED-1:0];
                    SEL_HEX:  hex_r <= wdata_i[4*N_DIG-1:0];
                    SEL_CTRL: begin
                        blank_r <= wdata_i[N_DIG-1:0];
                        dpm_r   <= wdata_i[8 +: N_DIG];
                        en_r    <= wdata_i[16];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux; unused bits and unmapped addresses return 0.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_LED:  rd_mux[N_LED-1:0]   = led_o;
            SEL_SW:   rd_mux[N_SW-1:0]    = sw_s2;
            SEL_BTN:  rd_mux[N_BTN-1:0]   = btn_deb;
            SEL_EVT:  rd_mux[N_BTN-1:0]   = evt;
            SEL_HEX:  rd_mux[4*N_DIG-1:0] = hex_r;
            SEL_CTRL: begin
                rd_mux[N_DIG-1:0]  = blank_r;
                rd_mux[8 +: N_DIG] = dpm_r;
                rd_mux[16]         = en_r;
            end
            default: ;
        endcase
    end

    // Read data holds until the next read strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= rd_mux;
        end
    end

    assign nibble = hex_r[32'(dig_idx) * 4 +: 4];

    // Digit scan; outputs are registered from the current index so segments,
    // dp and anode always change together.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_r) begin
            ref_cnt <= '0;
            dig_idx <= '0;
            an_o    <= '1;
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
        end else begin
            if (ref_cnt == REF_W'(REF_CYCLES - 1)) begin
                ref_cnt <= '0;
                dig_idx <= (dig_idx == IDX_W'(N_DIG - 1)) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
            an_o  <= blank_r[dig_idx] ? '1 : ~(N_DIG'(1) << dig_idx);
            seg_o <= hex_decode(nibble);
            dp_o  <= ~dpm_r[dig_idx];
        end
    end

endmodule

// File: tb/tb_basys_io_periph.sv
// Bench for basys_io_periph: directed scenarios with literal expectations
// followed by randomized bus/button/switch traffic, all cross-checked every
// cycle against a behavioural model of the register map, debounce and scan.
module tb_basys_io_periph;

    localparam int unsigned N_LED = 16;
    localparam int unsigned N_SW  = 16;
    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_DIG = 4;
    localparam int unsigned DEB   = 4;
    localparam int unsigned REF   = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       addr;
    logic             we, re;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [N_LED-1:0] led;
    logic [N_SW-1:0]  sw;
    logic [N_BTN-1:0] btn;
    logic [6:0]       seg;
    logic             dp;
    logic [N_DIG-1:0] an;

    int checks   = 0;
    int failures = 0;

    basys_io_periph #(
        .N_LED(N_LED), .N_SW(N_SW), .N_BTN(N_BTN), .N_DIG(N_DIG),
        .DEB_CYCLES(DEB), .REF_CYCLES(REF)
    ) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .we_i(we), .re_i(re),
        .wdata_i(wdata), .rdata_o(rdata), .led_o(led), .sw_i(sw), .btn_i(btn),
        .seg_o(seg), .dp_o(dp), .an_o(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Segment patterns with a lit segment as 1 (bit0 = a); the pins are the inverse.
    logic [6:0] seg_lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0]      m_led, m_hex, m_sw_d1, m_sw_d2;
    logic [N_BTN-1:0] m_btn_d1, m_btn_d2, m_deb, m_evt;
    logic [N_BTN-1:0] m_hist [DEB];
    logic [3:0]       m_blank, m_dpm;
    logic             m_en;
    int               m_run;
    logic             m_valid = 1'b0;
    logic [31:0]      exp_rdata = '0;
    logic [3:0]       exp_an = 4'hF;
    logic [6:0]       exp_seg = 7'h7F;
    logic             exp_dp = 1'b1;

    function automatic logic [31:0] model_read(input logic [2:0] s);
        case (s)
            3'd0: return {16'h0, m_led};
            3'd1: return {16'h0, m_sw_d2};
            3'd2: return {28'h0, m_deb};
            3'd3: return {28'h0, m_evt};
            3'd4: return {16'h0, m_hex};
            3'd5: return {15'h0, m_en, 4'h0, m_dpm, 4'h0, m_blank};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        int d;
        logic [N_BTN-1:0] r, clr;
        logic stable;
        if (rst) begin
            m_led = '0; m_hex = '0; m_sw_d1 = '0; m_sw_d2 = '0;
            m_btn_d1 = '0; m_btn_d2 = '0; m_deb = '0; m_evt = '0;
            for (int k = 0; k < int'(DEB); k++) m_hist[k] = '0;
            m_blank = '0; m_dpm = '0; m_en = 1'b0; m_run = 0;
            exp_rdata = '0; exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            m_valid = 1'b1;
        end else begin
            // Display: the n-th consecutive enabled cycle shows digit ((n-1)/REF) mod N_DIG.
            if (m_en) begin
                m_run++;
                d = ((m_run - 1) / int'(REF)) % int'(N_DIG);
                exp_an  = m_blank[d] ? 4'hF : ~(4'(1) << d);
                exp_seg = ~seg_lit[(m_hex >> (4 * d)) & 16'hF];
                exp_dp  = ~m_dpm[d];
            end else begin
                m_run = 0;
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end
            if (re) exp_rdata = model_read(addr[4:2]);
            // Debounce: accept a level once the last DEB synced samples all disagree with the current one.
            for (int k = int'(DEB) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_btn_d2;
            r = '0;
            for (int b = 0; b < int'(N_BTN); b++) begin
                stable = 1'b1;
                for (int k = 0; k < int'(DEB); k++)
                    if (m_hist[k][b] == m_deb[b]) stable = 1'b0;
                if (stable) begin
                    m_deb[b] = ~m_deb[b];
                    if (m_deb[b]) r[b] = 1'b1;
                end
            end
            clr = (we && addr[4:2] == 3'd3) ? wdata[N_BTN-1:0] : '0;
            m_evt = (m_evt & ~clr) | r;
            if (we) begin
                case (addr[4:2])
                    3'd0: m_led = wdata[15:0];
                    3'd4: m_hex = wdata[15:0];
                    3'd5: begin m_blank = wdata[3:0]; m_dpm = wdata[11:8]; m_en = wdata[16]; end
                    default: ;
                endcase
            end
            m_sw_d2 = m_sw_d1;  m_sw_d1 = sw;
            m_btn_d2 = m_btn_d1; m_btn_d1 = btn;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("led",   32'(led),   32'(m_led));
            chk("an",    32'(an),    32'(exp_an));
            chk("seg",   32'(seg),   32'(exp_seg));
            chk("dp",    32'(dp),    32'(exp_dp));
            chk("rdata", rdata,      exp_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk); addr = a; wdata = v; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk); addr = a; re = 1'b1;
        @(negedge clk); re = 1'b0; v = rdata;
    endtask

    logic [3:0] an_seq  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_seq [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
    logic       dp_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] rv;
        int nf;
        logic saw_b, found;
        rst = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
        sw = 16'h1234; btn = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_an",  32'(an),  32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp",  32'(dp),  32'h1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), rv);
            chk($sformatf("rst_read_%0d", i), rv, (i == 1) ? 32'h1234 : 32'h0);
        end

        // LED write / readback, RO write ignored
        wr(5'h00, 32'h0000A5C3);
        chk("led_write", 32'(led), 32'hA5C3);
        rd(5'h00, rv);  chk("led_read", rv, 32'h0000A5C3);
        wr(5'h04, 32'hFFFFFFFF);
        rd(5'h04, rv);  chk("sw_ro", rv, 32'h1234);

        // Short glitch rejected
        @(negedge clk); btn[1] = 1'b1;
        repeat (3) @(negedge clk); btn[1] = 1'b0;
        repeat (10) @(negedge clk);
        rd(5'h08, rv);  chk("glitch_btn", rv, 32'h0);
        rd(5'h0C, rv);  chk("glitch_evt", rv, 32'h0);
        // Held press accepted
        btn[1] = 1'b1;
        repeat (10) @(negedge clk);
        rd(5'h08, rv);  chk("press_btn", rv, 32'h2);
        rd(5'h0C, rv);  chk("press_evt", rv, 32'h2);
        wr(5'h0C, 32'h2);
        rd(5'h0C, rv);  chk("w1c_evt", rv, 32'h0);
        rd(5'h08, rv);  chk("w1c_btn", rv, 32'h2);
        btn[1] = 1'b0;
        repeat (10) @(negedge clk);

        // W1C write on the exact cycle btn0's press is accepted: set wins
        btn[0] = 1'b1;
        repeat (5) @(negedge clk);
        addr = 5'h0C; wdata = 32'h1; we = 1'b1;
        @(negedge clk); we = 1'b0;
        rd(5'h0C, rv);  chk("collide_evt", rv, 32'h1);
        wr(5'h0C, 32'h1);
        rd(5'h0C, rv);  chk("clear_evt", rv, 32'h0);
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Scan sequence
        wr(5'h10, 32'h00001A3F);
        wr(5'h14, 32'h00010200);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", i),  32'(an),  32'(an_seq[i / 4]));
            chk($sformatf("scan_seg_%0d", i), 32'(seg), 32'(seg_seq[i / 4]));
            chk($sformatf("scan_dp_%0d", i),  32'(dp),  32'(dp_seq[i / 4]));
        end
        // Blank digit 2
        wr(5'h14, 32'h00010004);
        nf = 0; saw_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an == 4'hF) nf++;
            if (an == 4'hB) saw_b = 1'b1;
        end
        chk("blank_dark_cycles", 32'(nf), 32'd4);
        chk("blank_no_dig2", 32'(saw_b), 32'h0);

        // Reset while digit 2 is driven
        wr(5'h14, 32'h00010200);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an == 4'hB) found = 1'b1;
        end
        chk("wait_dig2", 32'(found), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan_rst_an", 32'(an), 32'hF);
        rst = 1'b0;
        rd(5'h10, rv);  chk("midscan_rst_hex", rv, 32'h0);
        wr(5'h14, 32'h00010000);
        @(negedge clk);
        chk("restart_an",  32'(an),  32'hE);
        chk("restart_seg", 32'(seg), 32'h40);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            we    = ($urandom_range(0, 4) == 0);
            re    = ($urandom_range(0, 2) == 0);
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom();
            if (we && addr[4:2] == 3'd5 && $urandom_range(0, 3) != 0) wdata[16] = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = int'($urandom_range(0, N_BTN - 1));
                btn[b] = ~btn[b];
            end
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom());
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
